// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: handshake and operand bus of the ARM execute stage.
// master = upstream/writeback side, slave = the execute stage itself.
interface alu_exec_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Rn;
    logic [WIDTH-1:0] Operand2;
    logic [3:0]       ShifterFlags;
    logic [3:0]       ALUControl;
    logic [3:0]       Cond;
    logic             SetFlags;
    logic [3:0]       RdAddr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic [3:0]       ResultAddr;
    logic             WriteEn;
    logic [3:0]       Flags;

    modport master (
        output in_valid, Rn, Operand2, ShifterFlags, ALUControl, Cond,
               SetFlags, RdAddr, out_ready,
        input  in_ready, out_valid, Result, ResultAddr, WriteEn, Flags
    );

    modport slave (
        input  in_valid, Rn, Operand2, ShifterFlags, ALUControl, Cond,
               SetFlags, RdAddr, out_ready,
        output in_ready, out_valid, Result, ResultAddr, WriteEn, Flags
    );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: ARM data-processing execute stage behind the RSR shifter.
// Evaluates the condition field against the NZCV register it owns, runs the
// 16 DP opcodes and registers the result into a one-entry valid/ready slot.
// Optional macro ALU_EXEC_PERF_EN adds exec_count/skip_count outputs.
module alu_exec_stage #(
    parameter int unsigned WIDTH       = 32,
    parameter logic [3:0]  FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
`ifdef ALU_EXEC_PERF_EN
    output logic [31:0] exec_count,
    output logic [31:0] skip_count,
`endif
    alu_exec_stage_if.slave bus
);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       addr_q, addr_d;
    logic             we_q, we_d;
    logic [3:0]       flags_q, flags_d;

    logic             in_ready;
    logic             accept;
    logic             cond_pass;
    logic             is_compare;
    logic             flag_n, flag_z, flag_c, flag_v;

    logic [WIDTH:0]   add_a, add_b, sum;
    logic             carry_in;
    logic             is_arith;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] alu_res;
    logic             res_n, res_z, res_c, res_v;

    // Only the shifter carry is consumed; N, Z and V come from our own ALU.
    logic unused_shifter_bits;
    assign unused_shifter_bits = ^{bus.ShifterFlags[3:2], bus.ShifterFlags[0]};

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // A full slot only frees up when writeback takes it this cycle.
    assign in_ready   = !out_valid_q || bus.out_ready;
    assign accept     = bus.in_valid && in_ready;
    assign is_compare = (bus.ALUControl[3:2] == 2'b10);

    // Condition field against the flags as they stand in the accept cycle.
    always_comb begin
        cond_pass = 1'b1;
        case (bus.Cond)
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = flag_c && !flag_z;
            4'h9:    cond_pass = !flag_c || flag_z;
            4'hA:    cond_pass = (flag_n == flag_v);
            4'hB:    cond_pass = (flag_n != flag_v);
            4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
            4'hD:    cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

    // Operand steering: one shared WIDTH+1 adder, subtraction as a + ~b + cin.
    always_comb begin
        add_a     = {1'b0, bus.Rn};
        add_b     = {1'b0, bus.Operand2};
        carry_in  = 1'b0;
        is_arith  = 1'b1;
        logic_res = '0;
        case (bus.ALUControl)
            OP_SUB, OP_CMP: begin
                add_b    = {1'b0, ~bus.Operand2};
                carry_in = 1'b1;
            end
            OP_RSB: begin
                add_a    = {1'b0, bus.Operand2};
                add_b    = {1'b0, ~bus.Rn};
                carry_in = 1'b1;
            end
            OP_ADD, OP_CMN: carry_in = 1'b0;
            OP_ADC: carry_in = flag_c;
            OP_SBC: begin
                add_b    = {1'b0, ~bus.Operand2};
                carry_in = flag_c;
            end
            OP_RSC: begin
                add_a    = {1'b0, bus.Operand2};
                add_b    = {1'b0, ~bus.Rn};
                carry_in = flag_c;
            end
            OP_AND, OP_TST: begin
                is_arith  = 1'b0;
                logic_res = bus.Rn & bus.Operand2;
            end
            OP_EOR, OP_TEQ: begin
                is_arith  = 1'b0;
                logic_res = bus.Rn ^ bus.Operand2;
            end
            OP_ORR: begin
                is_arith  = 1'b0;
                logic_res = bus.Rn | bus.Operand2;
            end
            OP_MOV: begin
                is_arith  = 1'b0;
                logic_res = bus.Operand2;
            end
            OP_BIC: begin
                is_arith  = 1'b0;
                logic_res = bus.Rn & ~bus.Operand2;
            end
            default: begin
                is_arith  = 1'b0;
                logic_res = ~bus.Operand2;
            end
        endcase
    end

    assign sum = add_a + add_b + {{WIDTH{1'b0}}, carry_in};

    // Result and candidate flags; logical ops take C from the shifter, keep V.
    always_comb begin
        alu_res = is_arith ? sum[WIDTH-1:0] : logic_res;
        res_c   = is_arith ? sum[WIDTH] : bus.ShifterFlags[1];
        res_v   = is_arith ? ((add_a[MSB] == add_b[MSB]) && (sum[MSB] != add_a[MSB]))
                           : flag_v;
        res_n   = alu_res[MSB];
        res_z   = (alu_res == '0);
    end

    // Next slot and flags; a failed condition still occupies the slot in order.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        addr_d      = addr_q;
        we_d        = we_q;
        flags_d     = flags_q;
        if (accept) begin
            out_valid_d = 1'b1;
            addr_d      = bus.RdAddr;
            result_d    = cond_pass ? alu_res : '0;
            we_d        = cond_pass && !is_compare;
            if (cond_pass && (bus.SetFlags || is_compare))
                flags_d = {res_n, res_z, res_c, res_v};
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output slot and NZCV register; reset drops any held result immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            flags_q     <= FLAGS_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.Result     = result_q;
    assign bus.ResultAddr = addr_q;
    assign bus.WriteEn    = we_q;
    assign bus.Flags      = flags_q;

`ifdef ALU_EXEC_PERF_EN
    logic [31:0] exec_count_q, skip_count_q;

    // Accepted instructions split by condition outcome; both wrap at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_count_q <= '0;
            skip_count_q <= '0;
        end else if (accept) begin
            if (cond_pass) exec_count_q <= exec_count_q + 32'd1;
            else           skip_count_q <= skip_count_q + 32'd1;
        end
    end

    assign exec_count = exec_count_q;
    assign skip_count = skip_count_q;
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vectors, a behavioural reference model and a
// per-cycle compare process for alu_exec_stage.
`timescale 1ns/1ps
module tb_alu_exec_stage;
    localparam int unsigned W  = 32;
    localparam logic [3:0]  FR = 4'b0000;

    localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;
    localparam logic [3:0] C_EQ = 4'h0, C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB;
    localparam logic [3:0] C_GT = 4'hC, C_LE = 4'hD, C_VS = 4'h6, C_AL = 4'hE, C_NV = 4'hF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_exec_stage_if #(.WIDTH(W)) bus ();
`ifdef ALU_EXEC_PERF_EN
    logic [31:0] exec_count, skip_count;
`endif

    alu_exec_stage #(.WIDTH(W), .FLAGS_RESET(FR)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ALU_EXEC_PERF_EN
        .exec_count (exec_count),
        .skip_count (skip_count),
`endif
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic        m_valid;
    logic [31:0] m_result;
    logic [3:0]  m_addr;
    logic        m_we;
    logic [3:0]  m_flags;
    int          m_exec, m_skip, m_xfers, dut_xfers;
    logic [31:0] t_res;
    logic        t_we, t_pass;
    logic [3:0]  t_nf;

    function automatic void model_exec(
        input  logic [3:0]  op, cond,
        input  logic [31:0] rn, op2,
        input  logic [3:0]  sf,
        input  logic        s,
        input  logic [3:0]  f,
        output logic [31:0] res, output logic we, output logic pass, output logic [3:0] nf);
        logic n, z, c, v, nc, nv, arith, cmp;
        longint unsigned ua, ub, ures, brw;
        longint sa, sb, sres, cin;
        logic [31:0] r;
        {n, z, c, v} = f;
        case (cond)
            4'h0: pass = z;            4'h1: pass = !z;
            4'h2: pass = c;            4'h3: pass = !c;
            4'h4: pass = n;            4'h5: pass = !n;
            4'h6: pass = v;            4'h7: pass = !v;
            4'h8: pass = c && !z;      4'h9: pass = !c || z;
            4'hA: pass = (n == v);     4'hB: pass = (n != v);
            4'hC: pass = !z && (n == v);
            4'hD: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
        ua = rn; ub = op2;
        sa = $signed(rn); sb = $signed(op2);
        cin = c ? 1 : 0;
        brw = c ? 0 : 1;
        arith = 1'b1; ures = 0; sres = 0; nc = 1'b0; r = 32'h0;
        case (op)
            OP_ADD, OP_CMN: begin ures = ua + ub;       sres = sa + sb;       nc = (ures > 64'hFFFF_FFFF); end
            OP_ADC:         begin ures = ua + ub + cin; sres = sa + sb + cin; nc = (ures > 64'hFFFF_FFFF); end
            OP_SUB, OP_CMP: begin ures = ua - ub;       sres = sa - sb;       nc = (ua >= ub); end
            OP_RSB:         begin ures = ub - ua;       sres = sb - sa;       nc = (ub >= ua); end
            OP_SBC:         begin ures = ua - ub - brw; sres = sa - sb - brw; nc = (ua >= ub + brw); end
            OP_RSC:         begin ures = ub - ua - brw; sres = sb - sa - brw; nc = (ub >= ua + brw); end
            default:        arith = 1'b0;
        endcase
        if (arith) begin
            r  = ures[31:0];
            nv = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        end else begin
            case (op)
                OP_AND, OP_TST: r = rn & op2;
                OP_EOR, OP_TEQ: r = rn ^ op2;
                OP_ORR:         r = rn | op2;
                OP_MOV:         r = op2;
                OP_BIC:         r = rn & ~op2;
                default:        r = ~op2;
            endcase
            nc = sf[1];
            nv = v;
        end
        cmp = (op >= OP_TST) && (op <= OP_CMN);
        res = pass ? r : 32'h0;
        we  = pass && !cmp;
        nf  = (pass && (s || cmp)) ? {r[31], (r == 32'h0), nc, nv} : f;
    endfunction

    // Model advances on the same edges as the stage; reads only bench-driven inputs.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0; m_result = 32'h0; m_addr = 4'h0; m_we = 1'b0; m_flags = FR;
            m_exec = 0; m_skip = 0;
        end else begin
            if (m_valid && bus.out_ready) m_xfers++;
            if (bus.in_valid && (!m_valid || bus.out_ready)) begin
                model_exec(bus.ALUControl, bus.Cond, bus.Rn, bus.Operand2, bus.ShifterFlags,
                           bus.SetFlags, m_flags, t_res, t_we, t_pass, t_nf);
                m_valid = 1'b1; m_result = t_res; m_addr = bus.RdAddr; m_we = t_we; m_flags = t_nf;
                if (t_pass) m_exec++; else m_skip++;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison, well clear of the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
            chk("out_valid", bus.out_valid, m_valid);
            chk("Flags", bus.Flags, m_flags);
            if (m_valid) begin
                chk("Result", bus.Result, m_result);
                chk("ResultAddr", bus.ResultAddr, m_addr);
                chk("WriteEn", bus.WriteEn, m_we);
            end
`ifdef ALU_EXEC_PERF_EN
            chk("exec_count", exec_count, m_exec);
            chk("skip_count", skip_count, m_skip);
`endif
            if (!reset && bus.out_valid && bus.out_ready) dut_xfers++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic [31:0] rn,
                         input logic [31:0] op2, input logic [3:0] sf, input logic s,
                         input logic [3:0] rd);
        bus.in_valid = 1'b1; bus.ALUControl = op; bus.Cond = cond; bus.Rn = rn;
        bus.Operand2 = op2; bus.ShifterFlags = sf; bus.SetFlags = s; bus.RdAddr = rd;
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  cond;
        logic [31:0] rn;
        logic [31:0] op2;
        logic [3:0]  sf;
        logic        s;
    } vec_t;

    vec_t vecs [0:19];

    initial begin
        bus.in_valid = 1'b0; bus.Rn = '0; bus.Operand2 = '0; bus.ShifterFlags = 4'h0;
        bus.ALUControl = 4'h0; bus.Cond = C_AL; bus.SetFlags = 1'b0; bus.RdAddr = 4'h0;
        bus.out_ready = 1'b1;
        m_xfers = 0; dut_xfers = 0;
        vecs = '{
            '{OP_SBC, C_AL, 32'd10,        32'd3,         4'h0, 1'b1},
            '{OP_RSB, C_AL, 32'd3,         32'd10,        4'h0, 1'b1},
            '{OP_RSC, C_AL, 32'd5,         32'd5,         4'h0, 1'b1},
            '{OP_EOR, C_AL, 32'hFF00FF00,  32'h0F0F0F0F,  4'h0, 1'b1},
            '{OP_ORR, C_AL, 32'h00000011,  32'h00000100,  4'h2, 1'b0},
            '{OP_BIC, C_AL, 32'hFFFFFFFF,  32'h0000FFFF,  4'h2, 1'b1},
            '{OP_MVN, C_AL, 32'h00000000,  32'h00000000,  4'h0, 1'b1},
            '{OP_TST, C_AL, 32'h00000080,  32'h00000080,  4'h2, 1'b0},
            '{OP_TEQ, C_AL, 32'h12345678,  32'h12345678,  4'h0, 1'b0},
            '{OP_CMN, C_AL, 32'hFFFFFFFF,  32'h00000001,  4'h0, 1'b0},
            '{OP_MOV, C_HI, 32'h0,         32'h00000055,  4'h0, 1'b0},
            '{OP_MOV, C_LS, 32'h0,         32'h00000066,  4'h0, 1'b0},
            '{OP_SUB, C_AL, 32'h80000000,  32'h00000001,  4'h0, 1'b1},
            '{OP_MOV, C_GE, 32'h0,         32'h00000011,  4'h0, 1'b0},
            '{OP_MOV, C_LT, 32'h0,         32'h00000022,  4'h0, 1'b0},
            '{OP_MOV, C_GT, 32'h0,         32'h00000033,  4'h0, 1'b0},
            '{OP_MOV, C_LE, 32'h0,         32'h00000044,  4'h0, 1'b0},
            '{OP_MOV, C_VS, 32'h0,         32'h00000077,  4'h0, 1'b0},
            '{OP_MOV, C_NV, 32'h0,         32'h00000088,  4'h0, 1'b0},
            '{OP_ADD, C_AL, 32'hFFFFFFFF,  32'hFFFFFFFF,  4'h0, 1'b1}
        };

        // Reset values while reset is held
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_Result", bus.Result, 32'h0);
        chk("rst_ResultAddr", bus.ResultAddr, 4'h0);
        chk("rst_WriteEn", bus.WriteEn, 1'b0);
        chk("rst_Flags", bus.Flags, FR);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(OP_ADD, C_AL, 32'h7FFFFFFF, 32'd1, 4'h0, 1'b1, 4'd1);
        @(negedge clk); #1;
        chk("adds_res", bus.Result, 32'h80000000);
        chk("adds_we", bus.WriteEn, 1'b1);
        chk("adds_flags", bus.Flags, 4'b1001);

        issue(OP_SUB, C_AL, 32'd5, 32'd5, 4'h0, 1'b1, 4'd2);
        @(negedge clk); #1;
        chk("subs_res", bus.Result, 32'h0);
        chk("subs_flags", bus.Flags, 4'b0110);

        issue(OP_CMP, C_AL, 32'd3, 32'd5, 4'h0, 1'b0, 4'd3);
        @(negedge clk); #1;
        chk("cmp_we", bus.WriteEn, 1'b0);
        chk("cmp_res", bus.Result, 32'hFFFFFFFE);
        chk("cmp_flags", bus.Flags, 4'b1000);

        issue(OP_MOV, C_LT, 32'd0, 32'd9, 4'h0, 1'b0, 4'd4);
        @(negedge clk); #1;
        chk("movlt_we", bus.WriteEn, 1'b1);
        chk("movlt_res", bus.Result, 32'd9);

        issue(OP_MOV, C_EQ, 32'd0, 32'd7, 4'h0, 1'b1, 4'd5);
        @(negedge clk); #1;
        chk("moveq_valid", bus.out_valid, 1'b1);
        chk("moveq_we", bus.WriteEn, 1'b0);
        chk("moveq_res", bus.Result, 32'h0);
        chk("moveq_flags", bus.Flags, 4'b1000);

        issue(OP_ADD, C_AL, 32'h7FFFFFFF, 32'd1, 4'h0, 1'b1, 4'd6);
        @(negedge clk);
        issue(OP_AND, C_AL, 32'hF0, 32'h0F, 4'b0010, 1'b1, 4'd7);
        @(negedge clk); #1;
        chk("ands_res", bus.Result, 32'h0);
        chk("ands_flags", bus.Flags, 4'b0111);

        issue(OP_ADC, C_AL, 32'd1, 32'd2, 4'h0, 1'b1, 4'd8);
        @(negedge clk); #1;
        chk("adcs_res", bus.Result, 32'd4);
        chk("adcs_flags", bus.Flags, 4'b0000);

        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].op, vecs[i].cond, vecs[i].rn, vecs[i].op2, vecs[i].sf, vecs[i].s,
                  4'(i));
            @(negedge clk);
        end

        // Backpressure: known flags, drain, then stall three cycles
        issue(OP_CMP, C_AL, 32'd3, 32'd5, 4'h0, 1'b0, 4'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(OP_MOV, C_AL, 32'd0, 32'h1234, 4'h0, 1'b0, 4'd10);
        @(negedge clk);
        issue(OP_SUB, C_AL, 32'd5, 32'd5, 4'h0, 1'b1, 4'd11);
        #1;
        chk("bp_in_ready", bus.in_ready, 1'b0);
        chk("bp_res0", bus.Result, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("bp_stall_ready", bus.in_ready, 1'b0);
            chk("bp_stall_res", bus.Result, 32'h1234);
            chk("bp_stall_flags", bus.Flags, 4'b1000);
        end
        bus.out_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_rel_res", bus.Result, 32'h0);
        chk("bp_rel_addr", bus.ResultAddr, 4'd11);
        chk("bp_rel_flags", bus.Flags, 4'b0110);
        for (int i = 0; i < 4; i++) begin
            issue(OP_MOV, C_AL, 32'd0, 32'h100 + 32'(i), 4'h0, 1'b0, 4'(12 + i));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset while holding a result
        bus.out_ready = 1'b0;
        issue(OP_MOV, C_AL, 32'd0, 32'h1234, 4'h0, 1'b0, 4'd9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        chk("pre_rst_res", bus.Result, 32'h1234);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", bus.out_valid, 1'b0);
        chk("async_rst_flags", bus.Flags, FR);
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        issue(OP_MOV, C_AL, 32'd0, 32'hABCD, 4'h0, 1'b0, 4'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        chk("transfers", dut_xfers, m_xfers);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
